tube_readout_ctrl: RTL and testbench
====================================

# tube_readout_ctrl

Sequences one drift-tube event from scintillator trigger to RPi readout. A synchronized SCIN_COIN rising edge opens a fixed timing window. During the window a free-running 8-bit counter timestamps the first rising edge on each of the 32 tube channels (TUBE3A, TUBE3B, TUBE4A, TUBE4B, concatenated in that order). The controller then scans the channels and writes one {tube id, drift time} word per hit into the readout FIFO write port.

## Interface
- WINDOW, 100: timing-window length in clk100 cycles; legal range 1..255.
- NCHAN, 32: number of tube channels; fixed at 32 in this design.
- SYNC_STAGES, 2: synchronizer flops per asynchronous input; minimum 2.
- clk100  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- SCIN_COIN  in  1  asynchronous scintillator coincidence trigger.
- TUBE_HIT  in  32  asynchronous tube discriminator outputs; bit 0 = TUBE3A[0], bit 31 = TUBE4B[7].
- fifo_full  in  1  readout FIFO full flag, same clock domain.
- fifo_wr_en  out  1  one-cycle write strobe.
- fifo_wr_data  out  16  [15:8] tube id (0..31, or 0xFF for a header), [7:0] drift time or event id.
- busy  out  1  high in every state except IDLE.
- dropped_evt  out  8  count of triggers ignored while busy; saturates at 255.

## Operation
- Every input passes through SYNC_STAGES flops followed by a one-flop rising-edge detect. Only detected edges are acted on.
- States are IDLE, COLLECT, HDR, SCAN.
- **IDLE**
  - A trigger edge moves to COLLECT: the counter clears to 0, and the 32-bit hit mask and all timestamps clear.
  - Tube edges are ignored.
- **COLLECT**
  - The counter increments every cycle. A tube edge on a channel with its mask bit clear stores the current counter value and sets the mask bit.
  - Later edges on the same channel are ignored, so only the first hit per event is kept.
  - When the counter reaches WINDOW-1, that cycle still accepts hits. The next state is HDR if the header is enabled, else SCAN.
- **HDR**: writes {8'hFF, evt_id} when fifo_full is low, then goes to SCAN. While fifo_full is high it holds.
- **SCAN**
  - The channel index steps 0..31, one channel per cycle.
  - If the mask bit is set: write {index, timestamp} when fifo_full is low, otherwise hold the index without advancing.
  - Channels with the mask bit clear cost one cycle and produce no write.
  - After index 31 the state returns to IDLE and evt_id increments (8-bit, wraps 255->0).
- A trigger edge in any non-IDLE state, including the cycle of the COLLECT->HDR/SCAN transition, is dropped and increments dropped_evt.
- If a tube edge and the trigger edge arrive in the same IDLE cycle, the tube edge is discarded.
- **Reset**
  - Reset values: fifo_wr_en=0, fifo_wr_data=0, busy=0, dropped_evt=0, evt_id=0, state IDLE, mask cleared.
  - Reset mid-event abandons the event; no further writes for it.

## Timing
- Pin to detected edge takes SYNC_STAGES+1 cycles (3 by default). Timestamps are relative to trigger detection, so tube and trigger latencies cancel.
- The first COLLECT cycle has count 0. COLLECT lasts exactly WINDOW cycles.
- fifo_wr_en is registered and asserts only in a cycle where fifo_full was sampled low.
- An event with no FIFO stalls takes WINDOW + 32 cycles (+1 with the header) plus one cycle back to IDLE.
- busy rises the cycle after the trigger is detected and falls the cycle after the last SCAN cycle.

## Configuration
- HEADER_WORD_EN
  - Defined: the HDR state exists, and each event begins with {0xFF, evt_id}. An event with no hits writes only the header.
  - Undefined: there is no HDR state and no evt_id register. An event with no hits writes nothing.

## Structure
- qn_readout_pkg contains:
  - the state enum;
  - TUBE_ID_W=8 and TIME_W=8;
  - HEADER_MARK=8'hFF;
  - the word-packing function.
- Sub-module edge_sync holds the SYNC_STAGES synchronizer and rising-edge detect. It is instantiated 33 times (trigger plus 32 tubes).

## Test plan
- **Single hit**: trigger, then channel 5 rises 20 cycles later → header {FF,00}, then one word 0x05 with time 20. busy falls after WINDOW+33 cycles.
- **Multi-hit ordering and first-hit rule**: channels 31 (t=3), 0 (t=50), and 7 twice (t=10, t=60) → words in order 0x0032, 0x070A, 0x1F03.
- **Window edge**: hit at t=WINDOW-1=99 → recorded as 0x63. A hit at t=100 is not recorded.
- **FIFO backpressure**: fifo_full held high for 10 cycles during SCAN on channel 2 → no write while full, no words lost or duplicated, channel order preserved.
- **Retrigger**: second trigger edge during COLLECT, then another in SCAN → dropped_evt=2, first event output unaffected. 300 dropped triggers → dropped_evt saturates at 255.
- **Reset mid-event and evt_id wrap**: assert rst in COLLECT → busy=0 next cycle, no writes afterwards. 257 clean events → header ids run 00..FF, 00.

Source files
------------

// File: rtl/qn_readout_pkg.sv
// Shared types and helpers for the drift-tube readout controller.
// HEADER_WORD_EN adds the HDR state (per-event header word).
package qn_readout_pkg;
    localparam int TUBE_ID_W = 8;
    localparam int TIME_W    = 8;
    localparam int WORD_W    = TUBE_ID_W + TIME_W;
    localparam logic [TUBE_ID_W-1:0] HEADER_MARK = 8'hFF;

`ifdef HEADER_WORD_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HDR, S_SCAN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN} state_t;
`endif

    function automatic logic [WORD_W-1:0] pack_word(input logic [TUBE_ID_W-1:0] id,
                                                     input logic [TIME_W-1:0]    val);
        return {id, val};
    endfunction
endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for one asynchronous input followed by a rising-edge detect.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/tube_readout_ctrl.sv
// Drift-tube event sequencer: trigger opens a window, first tube hits are timestamped,
// then hit words are scanned out to the FIFO. HEADER_WORD_EN prepends {FF, evt_id}.
module tube_readout_ctrl
    import qn_readout_pkg::*;
#(
    parameter int WINDOW      = 100,
    parameter int NCHAN       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic              SCIN_COIN,
    input  logic [NCHAN-1:0]  TUBE_HIT,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_wr_data,
    output logic              busy,
    output logic [7:0]        dropped_evt
);
    localparam int IDX_W = $clog2(NCHAN);

    logic             trig_rise;
    logic [NCHAN-1:0] tube_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk_i(clk100), .rst_i(rst), .d_i(SCIN_COIN), .rise_o(trig_rise)
    );

    for (genvar g = 0; g < NCHAN; g++) begin : g_tube
        edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tube_sync (
            .clk_i(clk100), .rst_i(rst), .d_i(TUBE_HIT[g]), .rise_o(tube_rise[g])
        );
    end

    state_t                        state_q, state_d;
    logic [TIME_W-1:0]             cnt_q, cnt_d;
    logic [NCHAN-1:0]              mask_q, mask_d;
    logic [NCHAN-1:0][TIME_W-1:0]  ts_q, ts_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic                          wr_en_q, wr_en_d;
    logic [WORD_W-1:0]             wr_data_q, wr_data_d;
    logic [7:0]                    drop_q, drop_d;
`ifdef HEADER_WORD_EN
    logic [7:0]                    evt_q, evt_d;
`endif

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            ts_q      <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            drop_q    <= '0;
`ifdef HEADER_WORD_EN
            evt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            ts_q      <= ts_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
`ifdef HEADER_WORD_EN
            evt_q     <= evt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        ts_d      = ts_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        drop_d    = drop_q;
`ifdef HEADER_WORD_EN
        evt_d     = evt_q;
`endif

        if (trig_rise && state_q != S_IDLE && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                // Tube edges in IDLE, even coincident with the trigger, are discarded.
                if (trig_rise) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    mask_d  = '0;
                    ts_d    = '0;
                end
            end
            S_COLLECT: begin
                for (int c = 0; c < NCHAN; c++) begin
                    if (tube_rise[c] && !mask_q[c]) begin
                        mask_d[c] = 1'b1;
                        ts_d[c]   = cnt_q;
                    end
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TIME_W'(WINDOW - 1)) begin
                    idx_d = '0;
`ifdef HEADER_WORD_EN
                    state_d = S_HDR;
`else
                    state_d = S_SCAN;
`endif
                end
            end
`ifdef HEADER_WORD_EN
            S_HDR: begin
                if (!fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = pack_word(HEADER_MARK, evt_q);
                    state_d   = S_SCAN;
                end
            end
`endif
            S_SCAN: begin
                // A hit channel waits on a full FIFO; an empty channel always advances.
                if (!mask_q[idx_q] || !fifo_full) begin
                    if (mask_q[idx_q]) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = pack_word(TUBE_ID_W'(idx_q), ts_q[idx_q]);
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NCHAN - 1)) begin
                        state_d = S_IDLE;
`ifdef HEADER_WORD_EN
                        evt_d   = evt_q + 8'd1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign busy         = (state_q != S_IDLE);
    assign dropped_evt  = drop_q;
endmodule

// File: tb/tb_tube_readout_ctrl.sv
// Randomized bench for tube_readout_ctrl; expected words come from a per-event hit-list model.
module tb_tube_readout_ctrl;
    localparam int W = 100;
`ifdef HEADER_WORD_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic        clk100 = 1'b0;
    logic        rst = 1'b1;
    logic        SCIN_COIN = 1'b0;
    logic [31:0] TUBE_HIT = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        busy;
    logic [7:0]  dropped_evt;

    tube_readout_ctrl #(.WINDOW(W), .NCHAN(32), .SYNC_STAGES(2)) dut (
        .clk100(clk100), .rst(rst), .SCIN_COIN(SCIN_COIN), .TUBE_HIT(TUBE_HIT),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .dropped_evt(dropped_evt)
    );

    always #5 clk100 = ~clk100;

    int          n_chk = 0, n_pass = 0;
    int          hit_ch[$], hit_t[$], retrig_t[$];
    int          full_from, full_len;
    int          evt_m = 0, drop_m = 0;
    logic [15:0] obs_q[$], exp_q[$];
    int          busy_cnt, rise_n;
    int          rt, rn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_evt();
        hit_ch.delete(); hit_t.delete(); retrig_t.delete();
        full_from = 0; full_len = 0;
    endtask

    task automatic hit(input int ch, input int t);
        hit_ch.push_back(ch); hit_t.push_back(t);
    endtask

    // Sample outputs on the falling edge, before the next inputs are driven.
    task automatic step(input int n);
        @(negedge clk100);
        if (fifo_wr_en) obs_q.push_back(fifo_wr_data);
        if (fifo_full) chk("wr_while_full", {31'b0, fifo_wr_en}, 32'd0);
        if (busy) begin
            busy_cnt++;
            if (rise_n < 0) rise_n = n;
        end
    endtask

    // Trigger pin rises at n=0; a hit at window time t rises at n=t+1.
    task automatic run_event(input int rst_at);
        int          first[32];
        logic [31:0] hits;
        bit          trig;
        foreach (first[c]) first[c] = -1;
        foreach (hit_ch[k])
            if (hit_t[k] < W && (first[hit_ch[k]] < 0 || hit_t[k] < first[hit_ch[k]]))
                first[hit_ch[k]] = hit_t[k];
        exp_q.delete(); obs_q.delete();
        if (rst_at < 0) begin
            if (H == 1) exp_q.push_back({8'hFF, 8'(evt_m)});
            for (int c = 0; c < 32; c++)
                if (first[c] >= 0) exp_q.push_back({8'(c), 8'(first[c])});
            evt_m = (evt_m + 1) % 256;
            drop_m = drop_m + retrig_t.size();
            if (drop_m > 255) drop_m = 255;
        end else begin
            evt_m = 0; drop_m = 0;
        end
        busy_cnt = 0; rise_n = -1;
        for (int n = 0; n < W + 60; n++) begin
            step(n);
            if (rst_at >= 0 && n == rst_at)     chk("busy_pre_rst", {31'b0, busy}, 32'd1);
            if (rst_at >= 0 && n == rst_at + 1) chk("busy_post_rst", {31'b0, busy}, 32'd0);
            trig = (n < 2);
            foreach (retrig_t[k]) if (n == retrig_t[k] + 1 || n == retrig_t[k] + 2) trig = 1'b1;
            hits = '0;
            foreach (hit_ch[k]) if (n == hit_t[k] + 1 || n == hit_t[k] + 2) hits[hit_ch[k]] = 1'b1;
            SCIN_COIN = trig;
            TUBE_HIT  = hits;
            fifo_full = (n >= full_from && n < full_from + full_len);
            rst       = (rst_at >= 0 && n == rst_at);
        end
        chk("nwords", obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk("word", {16'b0, obs_q[k]}, {16'b0, exp_q[k]});
        chk("dropped", {24'b0, dropped_evt}, drop_m);
        if (rst_at < 0 && full_len == 0) begin
            chk("busy_len", busy_cnt, W + 32 + H);
            chk("busy_rise", rise_n, 3);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk100);
        chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("rst_wr_data", {16'b0, fifo_wr_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dropped", {24'b0, dropped_evt}, 32'd0);
        rst = 1'b0;

        clear_evt(); hit(5, 20); run_event(-1);
        clear_evt(); hit(31, 3); hit(0, 50); hit(7, 10); hit(7, 60); run_event(-1);
        clear_evt(); hit(9, W - 1); hit(10, W); run_event(-1);
        clear_evt(); hit(1, 5); hit(2, 6); hit(3, 7);
        full_from = 3 + W + H + 2; full_len = 10; run_event(-1);
        clear_evt(); hit(4, 7); retrig_t.push_back(30); retrig_t.push_back(W + H + 10); run_event(-1);
        clear_evt(); hit(3, 10); hit(8, 40); retrig_t.push_back(12); run_event(33);

        for (int s = 0; s < 10; s++) begin
            clear_evt(); hit(s, 2 * s + 1);
            for (int k = 0; k < 30; k++) retrig_t.push_back(2 + 4 * k);
            run_event(-1);
        end

        for (int e = 0; e < 250; e++) begin
            clear_evt();
            for (int c = 0; c < 32; c++) begin
                if ($urandom_range(9) == 0) begin
                    rt = int'($urandom_range(W + 10));
                    hit(c, rt);
                    if ($urandom_range(4) == 0) hit(c, rt + 4 + int'($urandom_range(30)));
                end
            end
            if ($urandom_range(4) == 0) begin
                rn = int'($urandom_range(1, 5));
                for (int j = 0; j < rn; j++) retrig_t.push_back(2 + 8 * j + int'($urandom_range(3)));
            end
            if ($urandom_range(2) == 0) begin
                full_from = int'($urandom_range(W + 40));
                full_len  = int'($urandom_range(1, 15));
            end
            run_event(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
